// File: rtl/core_seq.sv
// Tile instruction sequencer for core: weight load, kernel load, flush,
// activation load/execute, then OFIFO drain into pmem with a drain watchdog.
module core_seq #(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] wgt_base,
  input  logic [addr_width-1:0] act_base,
  input  logic [addr_width-1:0] psum_base,
  input  logic [addr_width-1:0] n_act,
  input  logic                  mode,
  input  logic                  relu,
  input  logic                  acc,
  input  logic                  ofifo_valid,
  output logic [35:0]           inst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  if (addr_width != 11 || row < 1 || col < 1 || psum_bw < bw ||
      row >= (1 << addr_width) || col >= (1 << addr_width)) begin : g_bad_cfg
    $error("core_seq: unsupported parameter combination");
  end

  localparam logic [35:0]           INST_IDLE = 36'h3_0018_0000;
  localparam logic [addr_width-1:0] ROW_C     = addr_width'(row);
  localparam logic [addr_width-1:0] COL_C     = addr_width'(col);

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_WKL, S_FLUSH, S_ALD, S_EXE, S_DRAIN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [addr_width-1:0] rd_cnt_q, rd_cnt_d;
  logic [addr_width-1:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]            wd_q, wd_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  err_q, err_d;
  logic [addr_width-1:0] wgt_base_q, act_base_q, psum_base_q, n_act_q;
  logic                  mode_q, relu_q, acc_q;

  logic                  accept;
  logic                  ofifo_rd;
  logic [addr_width-1:0] xaddr, paddr;

  assign accept   = (state_q == S_IDLE) && start;
  assign ofifo_rd = (state_q == S_DRAIN) && ofifo_valid && (rd_cnt_q < n_act_q);
  assign xaddr    = ((state_q == S_WLD) ? wgt_base_q : act_base_q) + cnt_q;
  assign paddr    = psum_base_q + wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      wd_q        <= '0;
      wr_pend_q   <= 1'b0;
      err_q       <= 1'b0;
      wgt_base_q  <= '0;
      act_base_q  <= '0;
      psum_base_q <= '0;
      n_act_q     <= '0;
      mode_q      <= 1'b0;
      relu_q      <= 1'b0;
      acc_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wd_q      <= wd_d;
      wr_pend_q <= wr_pend_d;
      err_q     <= err_d;
      if (accept) begin
        wgt_base_q  <= wgt_base;
        act_base_q  <= act_base;
        psum_base_q <= psum_base;
        n_act_q     <= n_act;
        mode_q      <= mode;
        relu_q      <= relu;
        acc_q       <= acc;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wd_d      = wd_q;
    wr_pend_d = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WLD;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      S_WLD: if (cnt_q == ROW_C) begin
        state_d = S_WKL;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      S_WKL: if (cnt_q == ROW_C - 1'b1) begin
        state_d = S_FLUSH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      S_FLUSH: if (cnt_q == COL_C - 1'b1) begin
        state_d = (n_act_q == '0) ? S_DONE : S_ALD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      S_ALD: if (cnt_q == n_act_q) begin
        state_d = S_EXE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      S_EXE: if (cnt_q == n_act_q - 1'b1) begin
        state_d  = S_DRAIN;
        cnt_d    = '0;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        wd_d     = '0;
      end else cnt_d = cnt_q + 1'b1;
      S_DRAIN: begin
        wr_pend_d = ofifo_rd;
        if (ofifo_rd) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          wd_d     = '0;
        end else wd_d = wd_q + 1'b1;
        if (wr_pend_q) wr_cnt_d = wr_cnt_q + 1'b1;
        // A timeout can only fire with no read this cycle, so no write is left behind.
        if (wr_pend_q && (wr_cnt_q == n_act_q - 1'b1)) state_d = S_DONE;
        else if ((wd_q == 8'hFF) && !ofifo_rd) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst = INST_IDLE;
    if (state_q != S_IDLE) begin
      inst[7]  = relu_q;
      inst[34] = acc_q;
      inst[35] = mode_q;
    end
    case (state_q)
      S_WLD: begin
        if (cnt_q < ROW_C) begin
          inst[20]   = 1'b0;
          inst[18:8] = xaddr;
        end
        if (cnt_q != '0) inst[6] = 1'b1;
      end
      S_WKL: begin
        inst[5] = 1'b1;
        inst[0] = 1'b1;
      end
      S_ALD: begin
        if (cnt_q < n_act_q) begin
          inst[20]   = 1'b0;
          inst[18:8] = xaddr;
        end
        if (cnt_q != '0) inst[6] = 1'b1;
      end
      S_EXE: begin
        inst[5] = 1'b1;
        inst[1] = 1'b1;
      end
      S_DRAIN: begin
        inst[2] = ofifo_rd;
        if (wr_pend_q) begin
          inst[33]    = 1'b0;
          inst[32]    = 1'b0;
          inst[31:21] = paddr;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: stimulus pushes expected xmem/pmem addresses,
// tile options and done-pulse properties; a negedge monitor pops and compares.
module tb_core_seq;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam logic [35:0] IDLE_INST = 36'h3_0018_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] wgt_base = '0, act_base = '0, psum_base = '0, n_act = '0;
  logic          mode = 1'b0, relu = 1'b0, acc = 1'b0, ofifo_valid = 1'b0;
  logic [35:0]   inst;
  logic          busy, done, err;

  core_seq #(.bw(4), .row(ROW), .col(COL), .psum_bw(16), .addr_width(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .wgt_base(wgt_base), .act_base(act_base), .psum_base(psum_base), .n_act(n_act),
    .mode(mode), .relu(relu), .acc(acc), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int lo; int hi; logic err; } done_t;

  int          checks = 0;
  int          errors = 0;
  int          xq[$];
  int          pq[$];
  logic [2:0]  oq[$];
  done_t       dq[$];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  logic       prev_busy = 1'b0, prev_rd = 1'b0, prev_ofrd = 1'b0;
  logic [2:0] cur_opt = '0;
  int         busy_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0; prev_rd = 1'b0; prev_ofrd = 1'b0; busy_len = 0;
    end else begin
      if (busy && !prev_busy) begin
        if (oq.size() == 0) check("unexpected_busy", 1, 0);
        else cur_opt = oq.pop_front();
      end
      if (busy) begin
        busy_len++;
        check("sticky_opts", {inst[35], inst[34], inst[7]}, cur_opt);
      end
      if (!busy && prev_busy) check("idle_inst", inst, IDLE_INST);
      if (!inst[20]) begin
        if (xq.size() == 0) check("unexpected_xmem_rd", inst[18:8], 0);
        else check("xmem_rd", {inst[19], inst[18:8]}, {1'b1, 11'(xq.pop_front())});
      end
      if (!inst[33]) begin
        if (pq.size() == 0) check("unexpected_pmem_wr", inst[31:21], 0);
        else check("pmem_wr", {inst[32], inst[31:21]}, {1'b0, 11'(pq.pop_front())});
      end
      if (inst[6] || prev_rd) check("l0_wr_lag", inst[6], prev_rd);
      if (!inst[33] || prev_ofrd) check("pmem_trail", !inst[33], prev_ofrd);
      if (inst[2]) check("ofifo_rd_valid", ofifo_valid, 1);
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          done_t d;
          d = dq.pop_front();
          checks++;
          if (busy_len < d.lo || busy_len > d.hi) begin
            errors++;
            $display("FAIL busy_len: got %0d expected %0d..%0d", busy_len, d.lo, d.hi);
          end
          check("done_err", err, d.err);
        end
      end
      if (!busy) busy_len = 0;
      prev_busy = busy;
      prev_rd   = !inst[20];
      prev_ofrd = inst[2];
    end
  end

  function automatic logic vfun(input int vmode, input int d);
    logic [5:0] pat;
    pat = 6'b111001;
    if (vmode == 2) return 1'b0;
    if (vmode == 1 && d >= 0 && d < 6) return pat[d];
    return 1'b1;
  endfunction

  task automatic run_tile(input int wb, input int ab, input int pb, input int n,
                          input logic m, input logic r, input logic a, input int vmode,
                          input bit poke, input int abort_c,
                          input int len_lo, input int len_hi, input logic exp_err);
    int  pre;
    int  c;
    bit  finished;
    done_t d;
    pre = 2*ROW + 1 + COL + 2*n + 1;
    for (int i = 0; i < ROW; i++) xq.push_back((wb + i) % 2048);
    for (int i = 0; i < n; i++) xq.push_back((ab + i) % 2048);
    if (vmode != 2) for (int i = 0; i < n; i++) pq.push_back((pb + i) % 2048);
    oq.push_back({m, a, r});
    d.lo = len_lo; d.hi = len_hi; d.err = exp_err;
    dq.push_back(d);

    @(posedge clk); #1;
    wgt_base = AW'(wb); act_base = AW'(ab); psum_base = AW'(pb); n_act = AW'(n);
    mode = m; relu = r; acc = a; ofifo_valid = vfun(vmode, -1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wgt_base = AW'($urandom); act_base = AW'($urandom); psum_base = AW'($urandom);
    n_act = AW'($urandom); mode = ~m; relu = ~r; acc = ~a;
    c = 1;
    finished = 0;
    while (!finished && c <= 400) begin
      if (abort_c == c) begin
        #2 reset = 1'b1;
        #1;
        check("abort_inst", inst, IDLE_INST);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        xq.delete(); pq.delete(); dq.delete(); oq.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      ofifo_valid = vfun(vmode, c - pre - 1);
      if (poke && c == 5) start = 1'b1;
      if (poke && c == 6) start = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
      end
      if (done) finished = 1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 400 cycles");
    end
  endtask

  initial begin
    #1;
    check("rst_inst", inst, IDLE_INST);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Abort mid-WKL, then nominal tile (with a start poked while busy)
    run_tile(0, 16, 100, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 12, 40, 40, 1'b0);
    run_tile(0, 16, 100, 4, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0, 40, 40, 1'b0);
    // Address wrap on xmem and pmem
    run_tile(2044, 2046, 2047, 4, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 40, 40, 1'b0);
    // OFIFO stall pattern 1,0,0,1,1,1
    run_tile(32, 48, 200, 4, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 42, 42, 1'b0);
    // Drain watchdog
    run_tile(64, 80, 300, 4, 1'b1, 1'b0, 1'b0, 2, 1'b0, 0, 289, 293, 1'b1);
    @(negedge clk);
    check("err_sticky", err, 1);
    // n_act = 0, then back-to-back start right after done
    run_tile(10, 20, 30, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 26, 26, 1'b0);
    run_tile(5, 7, 9, 2, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 34, 34, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("xq_empty", xq.size(), 0);
    check("pq_empty", pq.size(), 0);
    check("dq_empty", dq.size(), 0);
    check("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
